// File: rtl/serial_tl_host.sv
// Host-side endpoint of the 1-bit serial TileLink link: LSB-first word serializer and deserializer.
// Define SERIAL_TL_HOST_LOOPBACK_EN to add the loopback_i port (TX stream fed back into RX).
module serial_tl_host #(
   parameter int unsigned W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         tx_valid_i,
   output logic         tx_ready_o,
   input  logic [W-1:0] tx_data_i,
   output logic         rx_valid_o,
   input  logic         rx_ready_i,
   output logic [W-1:0] rx_data_o,
   output logic         serial_tl_bits_in_valid_o,
   output logic         serial_tl_bits_in_bits_o,
   input  logic         serial_tl_bits_in_ready_i,
   input  logic         serial_tl_bits_out_valid_i,
   input  logic         serial_tl_bits_out_bits_i,
`ifdef SERIAL_TL_HOST_LOOPBACK_EN
   input  logic         loopback_i,
`endif
   output logic         serial_tl_bits_out_ready_o
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(W - 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StShift = 1'b1;

   logic [0:0]    tx_state_q, tx_state_d;
   logic [W-1:0]  tx_shreg_q, tx_shreg_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic          tx_valid_int, tx_bit_int, tx_ready_int, tx_fire;

   logic [W-1:0]  rx_shreg_q, rx_shreg_d;
   logic [W-1:0]  rx_data_q, rx_data_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_valid_int, rx_bit_int, rx_ready_int, rx_fire;

   assign tx_valid_int = (tx_state_q == StShift);
   assign tx_bit_int   = tx_shreg_q[0];
   assign tx_fire      = tx_valid_int && tx_ready_int;

   // Stall only before the completing bit while the output word is still unclaimed.
   assign rx_ready_int = !(rx_valid_q && (rx_cnt_q == LastCnt));
   assign rx_fire      = rx_valid_int && rx_ready_int;

`ifdef SERIAL_TL_HOST_LOOPBACK_EN
   assign tx_ready_int               = loopback_i ? rx_ready_int : serial_tl_bits_in_ready_i;
   assign rx_valid_int               = loopback_i ? tx_valid_int : serial_tl_bits_out_valid_i;
   assign rx_bit_int                 = loopback_i ? tx_bit_int : serial_tl_bits_out_bits_i;
   assign serial_tl_bits_in_valid_o  = tx_valid_int && !loopback_i;
   assign serial_tl_bits_out_ready_o = rx_ready_int && !loopback_i;
`else
   assign tx_ready_int               = serial_tl_bits_in_ready_i;
   assign rx_valid_int               = serial_tl_bits_out_valid_i;
   assign rx_bit_int                 = serial_tl_bits_out_bits_i;
   assign serial_tl_bits_in_valid_o  = tx_valid_int;
   assign serial_tl_bits_out_ready_o = rx_ready_int;
`endif

   assign serial_tl_bits_in_bits_o = tx_bit_int;
   assign tx_ready_o               = (tx_state_q == StIdle);
   assign rx_valid_o               = rx_valid_q;
   assign rx_data_o                = rx_data_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shreg_d = tx_shreg_q;
      tx_cnt_d   = tx_cnt_q;
      case (tx_state_q)
         StIdle: begin
            if (tx_valid_i) begin
               tx_shreg_d = tx_data_i;
               tx_cnt_d   = '0;
               tx_state_d = StShift;
            end
         end
         StShift: begin
            if (tx_fire) begin
               tx_shreg_d = {1'b0, tx_shreg_q[W-1:1]};
               if (tx_cnt_q == LastCnt) begin
                  tx_cnt_d   = '0;
                  tx_state_d = StIdle;
               end else begin
                  tx_cnt_d = tx_cnt_q + CW'(1);
               end
            end
         end
         default: tx_state_d = StIdle;
      endcase
   end

   always_comb begin
      rx_shreg_d = rx_shreg_q;
      rx_data_d  = rx_data_q;
      rx_cnt_d   = rx_cnt_q;
      rx_valid_d = rx_valid_q;
      if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end
      if (rx_fire) begin
         rx_shreg_d = {rx_bit_int, rx_shreg_q[W-1:1]};
         if (rx_cnt_q == LastCnt) begin
            rx_data_d  = {rx_bit_int, rx_shreg_q[W-1:1]};
            rx_valid_d = 1'b1;
            rx_cnt_d   = '0;
         end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q <= StIdle;
         tx_shreg_q <= '0;
         tx_cnt_q   <= '0;
         rx_shreg_q <= '0;
         rx_data_q  <= '0;
         rx_cnt_q   <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shreg_q <= tx_shreg_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_shreg_q <= rx_shreg_d;
         rx_data_q  <= rx_data_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_valid_q <= rx_valid_d;
      end
   end

endmodule
